multi_buffer_ring_ctrl: RTL
===========================

// Module: multi_buffer_ring_ctrl
// PURPOSE
//  Single-clock N-buffer ring controller. Hands whole buffers (pages of 2**ADDR_WIDTH words in an
//  external simple-dual-port RAM) from a producer to a consumer via 4-phase req/ack/result and
//  finish/ack handshakes. Records per-buffer fill length, exposes occupancy, optionally overwrites
//  the oldest buffer when full. Sits between UART rx/tx datapaths and the shared packet RAM.
// PARAMETERS
//  DATA_WIDTH   8  RAM word width
//  ADDR_WIDTH   8  word address bits inside one buffer (depth 2**ADDR_WIDTH)
//  BUFFER_NUM   8  buffer count, >=2, need not be a power of two
//  BUF_AW       clog2(BUFFER_NUM)  buffer index width (derived)
//  OVERWRITE    0  1: write grant when full drops oldest unread buffer
// PORTS
//  clk_i            in   1   single clock
//  rst_i            in   1   reset, asynchronous, active-high
//  wr_req_i         in   1   producer requests a free buffer (hold until ack)
//  wr_req_ack_o     out  1   request answered
//  wr_req_result_o  out  1   1=granted, 0=refused (valid while ack=1)
//  wr_finish_i      in   1   producer done with buffer (hold until ack)
//  wr_finish_ack_o  out  1   finish accepted
//  wr_len_i         in   ADDR_WIDTH+1  words written, sampled on finish commit
//  wr_en_i          in   1   word write strobe
//  wr_addr_i        in   ADDR_WIDTH  word address in buffer
//  wr_data_i        in   DATA_WIDTH  write data
//  rd_req_i         in   1   consumer requests a full buffer
//  rd_req_ack_o     out  1   request answered
//  rd_req_result_o  out  1   1=granted, 0=nothing to read
//  rd_finish_i      in   1   consumer releases buffer
//  rd_finish_ack_o  out  1   release accepted
//  rd_len_o         out  ADDR_WIDTH+1  length of granted buffer
//  rd_addr_i        in   ADDR_WIDTH  read word address
//  rd_data_o        out  DATA_WIDTH  = ram_rd_data_i (pass-through)
//  ram_wr_en_o      out  1   wr_en_i & wr_own
//  ram_wr_addr_o    out  BUF_AW+ADDR_WIDTH  {wr_ptr, wr_addr_i}
//  ram_wr_data_o    out  DATA_WIDTH  wr_data_i
//  ram_rd_addr_o    out  BUF_AW+ADDR_WIDTH  {rd_ptr, rd_addr_i}
//  ram_rd_data_i    in   DATA_WIDTH  RAM read data
//  full_cnt_o       out  BUF_AW+1  committed unread buffers
//  full_o / empty_o out  1   full_cnt==BUFFER_NUM / full_cnt==0
//  overflow_o       out  1   1-cycle pulse when oldest buffer dropped
// BEHAVIOUR
//  Reset: all outputs 0 except empty_o=1; wr_ptr=rd_ptr=0, full_cnt=0, wr_own=rd_own=0, prio=WR.
//  Reset mid-handshake aborts it; acks fall asynchronously; ownership lost, lengths not cleared.
//  Request FSM: REQ_IDLE -> REQ_WR_JUDGE | REQ_RD_JUDGE -> REQ_WR_HOLD | REQ_RD_HOLD -> REQ_IDLE.
//   IDLE: only one req high -> judge it; both high -> side = prio, then prio flips.
//   WR_JUDGE: ack=1; result=1 if full_cnt<BUFFER_NUM, or if OVERWRITE & full & !rd_own (drop).
//   RD_JUDGE: ack=1; result=1 if full_cnt>0 (after any same-cycle drop); latch rd_len_o.
//   Granted result sets wr_own / rd_own. HOLD: wait req=0, then ack=0, result=0, IDLE.
//   Latency: req high at edge k -> ack/result high after edge k+1; ack low 1 edge after req low.
//  Finish FSM: BUF_IDLE -> BUF_WR_COMMIT | BUF_RD_RELEASE -> BUF_WR_WAIT | BUF_RD_WAIT -> BUF_IDLE.
//   Arbitration same rule as request FSM, own priority bit.
//   WR_COMMIT: finish_ack=1; if wr_own: len[wr_ptr]<=wr_len_i, wr_ptr++ , full_cnt++, wr_own=0.
//   RD_RELEASE: finish_ack=1; if rd_own: rd_ptr++, full_cnt--, rd_own=0.
//   Finish without ownership: handshake completes, no state change.
//   WAIT: finish low -> ack=0, BUF_IDLE.
//  Drop (overwrite grant when full): rd_ptr++, full_cnt--, overflow_o pulse in judge cycle.
//  full_cnt single update: +commit -release -drop, same cycle allowed; never exceeds BUFFER_NUM.
//  Pointers wrap BUFFER_NUM-1 -> 0. wr_len_i > 2**ADDR_WIDTH saturates to 2**ADDR_WIDTH.
//  Writes while !wr_own are suppressed at ram_wr_en_o.
// TESTING
//  1 BUFFER_NUM=3: 3x(wr grant, commit len=5) -> full_cnt 1,2,3, full_o=1; 4th wr req -> result=0.
//  2 wr req and rd req same cycle, full_cnt=1 -> WR judged first, RD next; both result=1.
//  3 OVERWRITE=1, full, rd idle: wr req -> result=1, overflow_o 1 cycle, rd_ptr 0->1, full_cnt 3->2->3.
//  4 Wrap BUFFER_NUM=3: 4 commits+reads -> ram_wr_addr_o buffer field 0,1,2,0; rd_len_o matches.
//  5 rd_finish with no grant -> ack=1 then 0, full_cnt unchanged; wr_en_i w/o grant -> ram_wr_en_o=0.
//  6 rst_i pulse during WR_HOLD -> acks 0 at once; after release empty_o=1, new wr req granted.

Source files
------------

// File: rtl/multi_buffer_ring_ctrl.sv
// Ring controller that hands whole RAM pages from a producer to a consumer.
// Request and finish handshakes each run their own FSM and share the ring state.
module multi_buffer_ring_ctrl #(
  parameter int unsigned  DATA_WIDTH = 8,
  parameter int unsigned  ADDR_WIDTH = 8,
  parameter int unsigned  BUFFER_NUM = 8,
  parameter bit           OVERWRITE  = 1'b0,
  localparam int unsigned BUF_AW     = $clog2(BUFFER_NUM)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_req_i,
  output logic                         wr_req_ack_o,
  output logic                         wr_req_result_o,
  input  logic                         wr_finish_i,
  output logic                         wr_finish_ack_o,
  input  logic [ADDR_WIDTH:0]          wr_len_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         rd_req_i,
  output logic                         rd_req_ack_o,
  output logic                         rd_req_result_o,
  input  logic                         rd_finish_i,
  output logic                         rd_finish_ack_o,
  output logic [ADDR_WIDTH:0]          rd_len_o,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         ram_wr_en_o,
  output logic [BUF_AW+ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]        ram_wr_data_o,
  output logic [BUF_AW+ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]        ram_rd_data_i,
  output logic [BUF_AW:0]              full_cnt_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overflow_o
);

  localparam int unsigned       LenW    = ADDR_WIDTH + 1;
  localparam int unsigned       CntW    = BUF_AW + 1;
  localparam logic [LenW-1:0]   MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CntW-1:0]   CntMax  = CntW'(BUFFER_NUM);
  localparam logic [BUF_AW-1:0] LastPtr = BUF_AW'(BUFFER_NUM - 1);

  typedef enum logic [2:0] {
    ReqIdle, ReqWrJudge, ReqRdJudge, ReqWrHold, ReqRdHold
  } req_state_e;

  typedef enum logic [2:0] {
    BufIdle, BufWrCommit, BufRdRelease, BufWrWait, BufRdWait
  } buf_state_e;

  req_state_e r_req_state, w_req_state_nxt;
  buf_state_e r_buf_state, w_buf_state_nxt;
  logic       r_req_prio, w_req_prio_nxt;  // 0: write side wins a tie
  logic       r_buf_prio, w_buf_prio_nxt;

  logic [BUF_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_full_cnt, w_full_cnt_nxt;
  logic              r_wr_own, r_rd_own;
  logic              r_wr_result, r_rd_result;
  logic [LenW-1:0]   r_rd_len;
  logic              r_overflow;
  logic [LenW-1:0]   r_len [BUFFER_NUM];

  logic            w_wr_grant, w_rd_grant, w_drop;
  logic            w_commit, w_release;
  logic [LenW-1:0] w_len_sat;

  function automatic logic [BUF_AW-1:0] ptr_inc(input logic [BUF_AW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign w_len_sat = (wr_len_i > MaxLen) ? MaxLen : wr_len_i;

  // Request FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_state <= ReqIdle;
      r_req_prio  <= 1'b0;
    end else begin
      r_req_state <= w_req_state_nxt;
      r_req_prio  <= w_req_prio_nxt;
    end
  end

  always_comb begin
    w_req_state_nxt = r_req_state;
    w_req_prio_nxt  = r_req_prio;
    w_wr_grant      = 1'b0;
    w_rd_grant      = 1'b0;
    w_drop          = 1'b0;
    unique case (r_req_state)
      ReqIdle: begin
        if (wr_req_i && rd_req_i) begin
          w_req_state_nxt = r_req_prio ? ReqRdJudge : ReqWrJudge;
          w_req_prio_nxt  = ~r_req_prio;
        end else if (wr_req_i) begin
          w_req_state_nxt = ReqWrJudge;
        end else if (rd_req_i) begin
          w_req_state_nxt = ReqRdJudge;
        end
      end
      ReqWrJudge: begin
        w_req_state_nxt = ReqWrHold;
        if (r_full_cnt != CntMax) begin
          w_wr_grant = 1'b1;
        end else if (OVERWRITE && !r_rd_own) begin
          // Ring is full: the oldest unread page is sacrificed to the writer.
          w_wr_grant = 1'b1;
          w_drop     = 1'b1;
        end
      end
      ReqRdJudge: begin
        w_req_state_nxt = ReqRdHold;
        w_rd_grant      = (r_full_cnt != '0);
      end
      ReqWrHold: if (!wr_req_i) w_req_state_nxt = ReqIdle;
      ReqRdHold: if (!rd_req_i) w_req_state_nxt = ReqIdle;
      default:   w_req_state_nxt = ReqIdle;
    endcase
  end

  // Finish FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf_state <= BufIdle;
      r_buf_prio  <= 1'b0;
    end else begin
      r_buf_state <= w_buf_state_nxt;
      r_buf_prio  <= w_buf_prio_nxt;
    end
  end

  always_comb begin
    w_buf_state_nxt = r_buf_state;
    w_buf_prio_nxt  = r_buf_prio;
    w_commit        = 1'b0;
    w_release       = 1'b0;
    unique case (r_buf_state)
      BufIdle: begin
        if (wr_finish_i && rd_finish_i) begin
          w_buf_state_nxt = r_buf_prio ? BufRdRelease : BufWrCommit;
          w_buf_prio_nxt  = ~r_buf_prio;
        end else if (wr_finish_i) begin
          w_buf_state_nxt = BufWrCommit;
        end else if (rd_finish_i) begin
          w_buf_state_nxt = BufRdRelease;
        end
      end
      BufWrCommit: begin
        w_buf_state_nxt = BufWrWait;
        w_commit        = r_wr_own;
      end
      BufRdRelease: begin
        w_buf_state_nxt = BufRdWait;
        w_release       = r_rd_own;
      end
      BufWrWait: if (!wr_finish_i) w_buf_state_nxt = BufIdle;
      BufRdWait: if (!rd_finish_i) w_buf_state_nxt = BufIdle;
      default:   w_buf_state_nxt = BufIdle;
    endcase
  end

  // Drop and release never coincide: drop needs !rd_own, release needs rd_own.
  always_comb begin
    w_full_cnt_nxt = r_full_cnt;
    if (w_commit && !(w_release || w_drop)) begin
      if (r_full_cnt != CntMax) w_full_cnt_nxt = r_full_cnt + 1'b1;
    end else if (!w_commit && (w_release || w_drop)) begin
      if (r_full_cnt != '0) w_full_cnt_nxt = r_full_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_full_cnt <= '0;
      r_wr_own   <= 1'b0;
      r_rd_own   <= 1'b0;
    end else begin
      if (w_commit) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_release || w_drop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_full_cnt <= w_full_cnt_nxt;
      if (w_wr_grant) begin
        r_wr_own <= 1'b1;
      end else if (w_commit) begin
        r_wr_own <= 1'b0;
      end
      if (w_rd_grant) begin
        r_rd_own <= 1'b1;
      end else if (w_release) begin
        r_rd_own <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_result <= 1'b0;
      r_rd_result <= 1'b0;
      r_rd_len    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (r_req_state == ReqWrJudge) begin
        r_wr_result <= w_wr_grant;
      end else if (r_req_state == ReqWrHold && !wr_req_i) begin
        r_wr_result <= 1'b0;
      end
      if (r_req_state == ReqRdJudge) begin
        r_rd_result <= w_rd_grant;
      end else if (r_req_state == ReqRdHold && !rd_req_i) begin
        r_rd_result <= 1'b0;
      end
      if (w_rd_grant) r_rd_len <= r_len[r_rd_ptr];
    end
  end

  // Page lengths survive reset; only committed pages are ever read back.
  always_ff @(posedge clk_i) begin
    if (w_commit) r_len[r_wr_ptr] <= w_len_sat;
  end

  assign wr_req_ack_o    = (r_req_state == ReqWrHold);
  assign rd_req_ack_o    = (r_req_state == ReqRdHold);
  assign wr_req_result_o = r_wr_result;
  assign rd_req_result_o = r_rd_result;
  assign wr_finish_ack_o = (r_buf_state == BufWrWait);
  assign rd_finish_ack_o = (r_buf_state == BufRdWait);
  assign rd_len_o        = r_rd_len;
  assign rd_data_o       = ram_rd_data_i;
  assign ram_wr_en_o     = wr_en_i & r_wr_own;
  assign ram_wr_addr_o   = {r_wr_ptr, wr_addr_i};
  assign ram_wr_data_o   = wr_data_i;
  assign ram_rd_addr_o   = {r_rd_ptr, rd_addr_i};
  assign full_cnt_o      = r_full_cnt;
  assign full_o          = (r_full_cnt == CntMax);
  assign empty_o         = (r_full_cnt == '0);
  assign overflow_o      = r_overflow;

endmodule
